// File: rtl/kgp_ctrl_sequencer.sv
// rtl/kgp_ctrl_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control sequencer for the KGP core
module kgp_ctrl_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opclass,
   input  logic       alu_carry,
   input  logic       mem_ready,
   output logic       ir_we,
   output logic       reg_we,
   output logic       mem_req,
   output logic       mem_we,
   output logic       pc_we,
   output logic [2:0] pc_update,
   output logic       carry_q,
   output logic [2:0] state,
   output logic       halted,
   output logic       mem_err
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_BRANCH = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [2:0] OP_STORE = 3'd3;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [2:0]       state_d;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_phase;
   logic             timeout;

   assign mem_phase = (state == S_FETCH) || (state == S_MEM);
   assign timeout   = mem_phase && !mem_ready && (wait_cnt == WAIT_LAST);

   always_comb begin
      state_d = S_HALT;
      case (state)
         S_FETCH:  state_d = mem_ready ? S_DECODE : (timeout ? S_HALT : S_FETCH);
         S_DECODE: begin
            case (opclass)
               3'd0, 3'd1, 3'd2, 3'd3: state_d = S_EXEC;
               3'd4, 3'd5, 3'd6:       state_d = S_BRANCH;
               default:                state_d = S_HALT;
            endcase
         end
         // classes 2/3 (load/store) share bit 1; 0/1 are ALU
         S_EXEC:   state_d = op_q[1] ? S_MEM : S_WB;
         S_MEM: begin
            if (mem_ready)
               state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
            else
               state_d = timeout ? S_HALT : S_MEM;
         end
         S_WB:     state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         default:  state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_FETCH;
         carry_q  <= 1'b0;
         mem_err  <= 1'b0;
         halted   <= 1'b0;
         wait_cnt <= '0;
         op_q     <= 3'd0;
      end else begin
         state  <= state_d;
         halted <= (state_d == S_HALT);
         if (timeout)
            mem_err <= 1'b1;
         if (state == S_DECODE)
            op_q <= opclass;
         if ((state == S_EXEC) && !op_q[1])
            carry_q <= alu_carry;
         // any exit from a waiting access state leaves the counter cleared
         if (mem_phase && !mem_ready && !timeout)
            wait_cnt <= wait_cnt + CNT_W'(1);
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      pc_we     = 1'b0;
      pc_update = 3'b000;
      if (rst) begin
         case (state)
            S_FETCH: begin
               mem_req = 1'b1;
               ir_we   = mem_ready;
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_we  = (op_q == OP_STORE);
               if (mem_ready && (op_q == OP_STORE)) begin
                  pc_we     = 1'b1;
                  pc_update = 3'b001;
               end
            end
            S_WB: begin
               reg_we    = 1'b1;
               pc_we     = 1'b1;
               pc_update = 3'b001;
            end
            S_BRANCH: begin
               pc_we = 1'b1;
               case (op_q)
                  3'd4:    pc_update = 3'b100;
                  3'd5:    pc_update = 3'b010;
                  3'd6:    pc_update = 3'b011;
                  default: pc_update = 3'b000;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_kgp_ctrl_sequencer.sv
// tb/tb_kgp_ctrl_sequencer.sv - directed-vector bench for kgp_ctrl_sequencer
module tb_kgp_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opclass;
   logic       alu_carry;
   logic       mem_ready;
   logic       ir_we, reg_we, mem_req, mem_we, pc_we;
   logic [2:0] pc_update;
   logic       carry_q;
   logic [2:0] state;
   logic       halted;
   logic       mem_err;
   logic [7:0] strb;

   int n_vec = 0;
   int n_err = 0;

   kgp_ctrl_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .opclass   (opclass),
      .alu_carry (alu_carry),
      .mem_ready (mem_ready),
      .ir_we     (ir_we),
      .reg_we    (reg_we),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .pc_we     (pc_we),
      .pc_update (pc_update),
      .carry_q   (carry_q),
      .state     (state),
      .halted    (halted),
      .mem_err   (mem_err)
   );

   always #5 clk = ~clk;

   // {ir_we, reg_we, mem_req, mem_we, pc_we, pc_update[2:0]}
   assign strb = {ir_we, reg_we, mem_req, mem_we, pc_we, pc_update};

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one clock: drive inputs just after the edge, check at the falling edge
   task automatic cyc(input string tag, input logic [2:0] opc, input logic mr, input logic ac,
                      input logic [2:0] es, input logic [7:0] est);
      opclass   = opc;
      mem_ready = mr;
      alu_carry = ac;
      @(negedge clk);
      chk({tag, ".state"}, 8'(state), 8'(es));
      chk({tag, ".strb"}, strb, est);
      chk({tag, ".halted"}, 8'(halted), 8'(es == 3'd6));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #3;
      chk("rst.state", 8'(state), 8'd0);
      chk("rst.carry", 8'(carry_q), 8'd0);
      chk("rst.mem_err", 8'(mem_err), 8'd0);
      chk("rst.halted", 8'(halted), 8'd0);
      chk("rst.strb", strb, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst.mem_req", 8'(mem_req), 8'd1);
   endtask

   initial begin
      rst       = 1'b0;
      opclass   = 3'd0;
      alu_carry = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // ALU-reg, carry out 1
      cyc("alu.f", 3'd0, 1'b1, 1'b0, 3'd0, 8'hA0);
      cyc("alu.d", 3'd0, 1'b1, 1'b0, 3'd1, 8'h00);
      chk("alu.carry_pre", 8'(carry_q), 8'd0);
      cyc("alu.e", 3'd3, 1'b1, 1'b1, 3'd2, 8'h00);
      chk("alu.carry_wb", 8'(carry_q), 8'd1);
      cyc("alu.w", 3'd3, 1'b1, 1'b0, 3'd4, 8'h49);

      // load with two MEM wait cycles
      cyc("ld.f", 3'd2, 1'b1, 1'b0, 3'd0, 8'hA0);
      cyc("ld.d", 3'd2, 1'b1, 1'b0, 3'd1, 8'h00);
      cyc("ld.e", 3'd0, 1'b1, 1'b0, 3'd2, 8'h00);
      cyc("ld.m0", 3'd0, 1'b0, 1'b0, 3'd3, 8'h20);
      cyc("ld.m1", 3'd0, 1'b0, 1'b0, 3'd3, 8'h20);
      cyc("ld.m2", 3'd0, 1'b1, 1'b0, 3'd3, 8'h20);
      cyc("ld.w", 3'd0, 1'b1, 1'b0, 3'd4, 8'h49);
      chk("ld.carry", 8'(carry_q), 8'd1);

      // store, then branch-on-carry
      cyc("st.f", 3'd3, 1'b1, 1'b0, 3'd0, 8'hA0);
      cyc("st.d", 3'd3, 1'b1, 1'b0, 3'd1, 8'h00);
      cyc("st.e", 3'd0, 1'b1, 1'b0, 3'd2, 8'h00);
      cyc("st.m", 3'd0, 1'b1, 1'b0, 3'd3, 8'h39);
      cyc("bc.f", 3'd5, 1'b1, 1'b0, 3'd0, 8'hA0);
      cyc("bc.d", 3'd5, 1'b1, 1'b0, 3'd1, 8'h00);
      cyc("bc.b", 3'd0, 1'b1, 1'b0, 3'd5, 8'h0A);
      chk("bc.carry", 8'(carry_q), 8'd1);

      // jump and flag branch
      cyc("jmp.f", 3'd4, 1'b1, 1'b0, 3'd0, 8'hA0);
      cyc("jmp.d", 3'd4, 1'b1, 1'b0, 3'd1, 8'h00);
      cyc("jmp.b", 3'd1, 1'b1, 1'b0, 3'd5, 8'h0C);
      cyc("bf.f", 3'd6, 1'b1, 1'b0, 3'd0, 8'hA0);
      cyc("bf.d", 3'd6, 1'b1, 1'b0, 3'd1, 8'h00);
      cyc("bf.b", 3'd2, 1'b1, 1'b0, 3'd5, 8'h0B);
      chk("bf.carry", 8'(carry_q), 8'd1);

      // fetch timeout: exactly 15 waiting cycles, then HALT
      for (int i = 0; i < 15; i++)
         cyc($sformatf("tmo.f%0d", i), 3'd0, 1'b0, 1'b0, 3'd0, 8'h20);
      chk("tmo.mem_err", 8'(mem_err), 8'd1);
      cyc("tmo.h", 3'd0, 1'b1, 1'b0, 3'd6, 8'h00);
      do_reset();

      // ready on the last permitted cycle is success; then halt opcode
      for (int i = 0; i < 14; i++)
         cyc($sformatf("edge.f%0d", i), 3'd7, 1'b0, 1'b0, 3'd0, 8'h20);
      cyc("edge.ok", 3'd7, 1'b1, 1'b0, 3'd0, 8'hA0);
      cyc("hop.d", 3'd7, 1'b1, 1'b0, 3'd1, 8'h00);
      chk("edge.mem_err", 8'(mem_err), 8'd0);
      for (int i = 0; i < 20; i++)
         cyc($sformatf("hop.h%0d", i), 3'(i), 1'b1, 1'b1, 3'd6, 8'h00);
      chk("hop.mem_err", 8'(mem_err), 8'd0);
      do_reset();

      // set carry, then abort an ALU op in EXEC with an asynchronous reset
      cyc("alu2.f", 3'd0, 1'b1, 1'b0, 3'd0, 8'hA0);
      cyc("alu2.d", 3'd0, 1'b1, 1'b0, 3'd1, 8'h00);
      cyc("alu2.e", 3'd0, 1'b1, 1'b1, 3'd2, 8'h00);
      cyc("alu2.w", 3'd0, 1'b1, 1'b0, 3'd4, 8'h49);
      chk("alu2.carry", 8'(carry_q), 8'd1);
      cyc("ab.f", 3'd1, 1'b1, 1'b0, 3'd0, 8'hA0);
      cyc("ab.d", 3'd1, 1'b1, 1'b0, 3'd1, 8'h00);
      alu_carry = 1'b0;
      #1;
      chk("ab.exec", 8'(state), 8'd2);
      #1;
      rst = 1'b0;
      #1;
      chk("ab.state", 8'(state), 8'd0);
      chk("ab.carry", 8'(carry_q), 8'd0);
      chk("ab.strb", strb, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc("ab.f2", 3'd0, 1'b0, 1'b0, 3'd0, 8'h20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/kgp_ctrl_sequencer.md
# kgp_ctrl_sequencer

Multi-cycle control sequencer for the KGP RISC core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the register, IR, PC and memory strobes, and generates the 3-bit PC-update code consumed by the branch-select logic. It also holds the architectural carry flag that conditional branches test, and it halts on a memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready per access; must be ≥1.
- CNT_W, 4: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- opclass  in  3  decoded class: 0 ALU-reg, 1 ALU-imm, 2 load, 3 store, 4 jump, 5 branch-on-carry, 6 branch-on-flag, 7 halt. Sampled in DECODE only.
- alu_carry  in  1  ALU carry-out. Sampled in EXEC for classes 0/1.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_we  out  1  load instruction register.
- reg_we  out  1  register-file write enable.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write (store); valid only with mem_req.
- pc_we  out  1  PC write enable.
- pc_update  out  3  code to branch select: 000 hold, 001 sequential, 010 carry-conditional, 011 flag-conditional, 100 jump target.
- carry_q  out  1  registered carry flag.
- state  out  3  current state encoding, for debug.
- halted  out  1  core stopped.
- mem_err  out  1  sticky memory-timeout error.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, HALT=6. Encoding 7 is illegal and goes to HALT with mem_err unchanged.
- FETCH: mem_req=1, mem_we=0. When mem_ready=1, assert ir_we and go to DECODE. Otherwise stay and increment wait_cnt.
- DECODE: no strobes. Next state by opclass:
  - 0–3 go to EXEC.
  - 4–6 go to BRANCH; opclass is latched into br_kind.
  - 7 goes to HALT.
- EXEC:
  - Classes 0/1: carry_q ← alu_carry, then go to WB.
  - Classes 2/3: go to MEM.
  - Class is held in the latched opclass register.
- MEM: mem_req=1, and mem_we=1 for a store. When mem_ready=1:
  - A store asserts pc_we with pc_update=001, then goes to FETCH.
  - A load goes to WB.
  - Otherwise stay and increment wait_cnt.
- WB: reg_we=1, pc_we=1, pc_update=001, then go to FETCH.
- BRANCH: pc_we=1. pc_update is 100, 010 or 011 for br_kind 4, 5 or 6 respectively. Then go to FETCH.
- HALT: all strobes 0, halted=1. Stays in HALT until reset.
- pc_update is 000 in every cycle where pc_we=0.
- Wait counter:
  - Cleared on entry to FETCH or MEM and whenever mem_ready=1.
  - If mem_ready is still 0 when wait_cnt==MEM_TIMEOUT-1, set mem_err=1 and go to HALT next cycle. No ir_we or pc_we is issued in that case.
- carry_q is written only in EXEC for ALU classes. Loads, stores and branches leave it unchanged.

## Timing
- Reset (rst=0), asynchronous: state=FETCH, carry_q=0, mem_err=0, halted=0, wait_cnt=0, latched opclass=0. All strobes are 0 except mem_req, which is 1 once rst deasserts because FETCH requests.
- Strobes are combinational from state, latched opclass and mem_ready. carry_q, state, halted and mem_err are registered.
- Latency with mem_ready tied high:
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch or jump: 3 cycles.
  - Each wait cycle in FETCH or MEM adds 1.
- A conditional branch sees the carry_q written by the most recent preceding ALU EXEC. The update lands at the edge ending EXEC, so it is always visible to a following BRANCH.
- Timeout: an access with mem_ready held 0 spends exactly MEM_TIMEOUT cycles in FETCH or MEM, then enters HALT.
- mem_ready=1 on the final permitted cycle counts as success, not a timeout.
- Reset asserted mid-instruction aborts immediately. No partial writes occur after the asynchronous clear.

## Test plan
- Reset, then ALU-reg with mem_ready=1 and alu_carry=1: states 0,1,2,4,0; reg_we and pc_we with pc_update=001 in cycle 4; carry_q=1 from cycle 4.
- Load with mem_ready low for 2 cycles in MEM: 7 cycles total; reg_we only in WB; pc_update=000 in every other cycle.
- Store then branch-on-carry (opclass 5) with carry_q=1 from a prior ALU op: mem_we=1 in the MEM cycle; BRANCH emits pc_update=010 with pc_we=1; carry_q stays 1.
- Jump (opclass 4) and flag branch (opclass 6): pc_update=100 and 011 respectively, each on the third cycle.
- FETCH with mem_ready=0 held, MEM_TIMEOUT=15: 15 cycles in FETCH, then HALT with mem_err=1 and halted=1. No ir_we is issued. rst=0 clears both flags.
- Halt opcode (opclass 7): HALT after DECODE, and all strobes stay 0 for 20 cycles. Reset asserted mid-EXEC returns state to 0 asynchronously with carry_q=0.
